// File: rtl/free_list_pkg.sv
// Shared rename-stage constants and types for the R10K free list and the
// branch-stack checkpoint records that capture its head pointer.
package free_list_pkg;

  localparam int PHYS_REG_SZ_R10K = 64;
  localparam int ARCH_REG_SZ      = 32;
  localparam int N_WAY            = 3;

  localparam int FL_SZ    = PHYS_REG_SZ_R10K - ARCH_REG_SZ;
  localparam int FL_PTR_W = $clog2(FL_SZ) + 1;

  typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PHYS_REG_IDX;
  typedef logic [FL_PTR_W-1:0]                 FL_PTR;

endpackage

// File: rtl/free_list.sv
// N-way circular free list of physical register tags: dispatch pops from the
// head, retirement pushes T_old at the tail, mispredicts restore the head.
module free_list
  import free_list_pkg::*;
#(
  parameter int DEPTH     = PHYS_REG_SZ_R10K,
  parameter int ARCH_REGS = ARCH_REG_SZ,
  parameter int N         = N_WAY,
  localparam int SZ       = DEPTH - ARCH_REGS,
  localparam int PTR_W    = $clog2(SZ) + 1,
  localparam int REG_W    = $clog2(DEPTH),
  localparam int NA_W     = $clog2(N + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NA_W-1:0]           rd_num,
  input  logic [N-1:0][REG_W-1:0]   wr_reg,
  input  logic [NA_W-1:0]           wr_num,
  input  logic                      br_en,
  input  logic [PTR_W-1:0]          br_head,
  output logic [N-1:0][REG_W-1:0]   free_regs,
  output logic [NA_W-1:0]           num_avail,
  output logic [PTR_W-1:0]          out_head
`ifdef DEBUG
  ,
  output logic [SZ-1:0][REG_W-1:0]  debug_entries,
  output logic [PTR_W-1:0]          debug_head,
  output logic [PTR_W-1:0]          debug_tail
`endif
);

  localparam int IW = PTR_W - 1;

  logic [REG_W-1:0] entries [SZ];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] next_head;
  logic [PTR_W-1:0] next_tail;
  logic [NA_W-1:0]  pop;
  logic [IW-1:0]    rd_idx [N];
  logic [IW-1:0]    wr_idx [N];

  // The wrap bit makes tail - head distinguish a full list (SZ) from an empty one (0).
  assign count     = tail - head;
  assign num_avail = (count >= PTR_W'(N)) ? NA_W'(N) : NA_W'(count);
  assign out_head  = head;

  always_comb begin
    pop       = (rd_num > num_avail) ? num_avail : rd_num;
    next_head = br_en ? br_head : head + PTR_W'(pop);
    next_tail = tail + PTR_W'(wr_num);
  end

  for (genvar g = 0; g < N; g++) begin : g_port
    assign rd_idx[g]    = head[IW-1:0] + IW'(g);
    assign wr_idx[g]    = tail[IW-1:0] + IW'(g);
    assign free_regs[g] = entries[rd_idx[g]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SZ; i++) entries[i] <= REG_W'(ARCH_REGS + i);
      head <= '0;
      tail <= PTR_W'(SZ);
    end else begin
      head <= next_head;
      tail <= next_tail;
      for (int i = 0; i < N; i++)
        if (i < int'(wr_num)) entries[wr_idx[i]] <= wr_reg[i];
    end
  end

  // Retirement can only return tags that were handed out, so a push never overflows.
  always_ff @(posedge clock) begin
    if (!reset) assert (int'(count) + int'(wr_num) <= SZ);
  end

`ifdef DEBUG
  for (genvar e = 0; e < SZ; e++) begin : g_dbg
    assign debug_entries[e] = entries[e];
  end
  assign debug_head = head;
  assign debug_tail = tail;
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector table, hand sequences for
// wrap and branch recovery, and random traffic against an unbounded-log model.
module tb_free_list;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       rd_num;
  logic [2:0][5:0]  wr_reg;
  logic [1:0]       wr_num;
  logic             br_en;
  logic [5:0]       br_head;
  logic [2:0][5:0]  free_regs;
  logic [1:0]       num_avail;
  logic [5:0]       out_head;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]      rd_num;
    logic [1:0]      wr_num;
    logic [2:0][5:0] wr_reg;
    logic [1:0]      exp_avail;
    logic [5:0]      exp_head;
    logic [2:0][5:0] exp_free;
  } vec_t;

  vec_t vecs[$];

  // Model: every tag ever made free is appended to a log; head/tail are absolute positions.
  int log_q[$];
  int head_abs;
  int ckpt_abs;
  int ckpt_valid;

  free_list dut (
    .clock     (clock),
    .reset     (reset),
    .rd_num    (rd_num),
    .wr_reg    (wr_reg),
    .wr_num    (wr_num),
    .br_en     (br_en),
    .br_head   (br_head),
    .free_regs (free_regs),
    .num_avail (num_avail),
    .out_head  (out_head)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int exp_avail, input int exp_head,
                             input int e0, input int e1, input int e2);
    int e [3];
    e = '{e0, e1, e2};
    check({name, " num_avail"}, 32'(num_avail), 32'(exp_avail));
    check({name, " out_head"}, 32'(out_head), 32'(exp_head));
    for (int i = 0; i < exp_avail; i++)
      check($sformatf("%s free_regs[%0d]", name, i), 32'(free_regs[i]), 32'(e[i]));
  endtask

  task automatic applyStimulus(input int rd, input int wr, input int w0, input int w1,
                               input int w2, input int br, input int bh);
    rd_num    = 2'(rd);
    wr_num    = 2'(wr);
    wr_reg[0] = 6'(w0);
    wr_reg[1] = 6'(w1);
    wr_reg[2] = 6'(w2);
    br_en     = br[0];
    br_head   = 6'(bh);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic addVec(input int rd, input int wr, input int w0, input int w1, input int w2,
                        input int avail, input int hd, input int f0, input int f1, input int f2);
    vec_t v;
    v.rd_num      = 2'(rd);
    v.wr_num      = 2'(wr);
    v.wr_reg[0]   = 6'(w0);
    v.wr_reg[1]   = 6'(w1);
    v.wr_reg[2]   = 6'(w2);
    v.exp_avail   = 2'(avail);
    v.exp_head    = 6'(hd);
    v.exp_free[0] = 6'(f0);
    v.exp_free[1] = 6'(f1);
    v.exp_free[2] = 6'(f2);
    vecs.push_back(v);
  endtask

  task automatic modelCheck(input int cyc);
    int cnt;
    int avail;
    cnt   = log_q.size() - head_abs;
    avail = (cnt < 3) ? cnt : 3;
    check($sformatf("rand%0d num_avail", cyc), 32'(num_avail), 32'(avail));
    check($sformatf("rand%0d out_head", cyc), 32'(out_head), 32'(head_abs % 64));
    for (int i = 0; i < avail; i++)
      check($sformatf("rand%0d free_regs[%0d]", cyc, i), 32'(free_regs[i]),
            32'(log_q[head_abs + i]));
  endtask

  initial begin
    reset   = 1'b1;
    rd_num  = '0;
    wr_num  = '0;
    wr_reg  = '0;
    br_en   = 1'b0;
    br_head = '0;

    for (int k = 0; k < 5; k++) addVec(0, 0, 0, 0, 0, 3, 0, 32, 33, 34);
    for (int k = 0; k < 10; k++) addVec(3, 0, 0, 0, 0, 3, 3 * k, 32 + 3 * k, 33 + 3 * k, 34 + 3 * k);
    addVec(2, 0, 0, 0, 0, 2, 30, 62, 63, 0);
    addVec(3, 0, 0, 0, 0, 0, 32, 0, 0, 0);
    addVec(3, 3, 5, 9, 12, 0, 32, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 3, 32, 5, 9, 12);

    doReset();
    foreach (vecs[k]) begin
      checkOutput($sformatf("vec%0d", k), int'(vecs[k].exp_avail), int'(vecs[k].exp_head),
                  int'(vecs[k].exp_free[0]), int'(vecs[k].exp_free[1]), int'(vecs[k].exp_free[2]));
      applyStimulus(int'(vecs[k].rd_num), int'(vecs[k].wr_num), int'(vecs[k].wr_reg[0]),
                    int'(vecs[k].wr_reg[1]), int'(vecs[k].wr_reg[2]), 0, 0);
    end

    // Wrap: the freed tags come back in FIFO order after the index passes 31.
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(3, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 10; b++) applyStimulus(0, 3, 32 + 3 * b, 33 + 3 * b, 34 + 3 * b, 0, 0);
    checkOutput("wrap_pre", 3, 30, 62, 63, 32);
    applyStimulus(3, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_mid", 3, 33, 33, 34, 35);
    applyStimulus(3, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_post", 3, 36, 36, 37, 38);

    // Recovery with a same-cycle free: reclaimed tags plus tag 7 at index 0.
    doReset();
    applyStimulus(3, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("br_ckpt", 3, 4, 36, 37, 38);
    for (int k = 0; k < 3; k++) applyStimulus(3, 0, 0, 0, 0, 0, 0);
    checkOutput("br_spec", 3, 13, 45, 46, 47);
    applyStimulus(3, 1, 7, 0, 0, 1, 4);
    checkOutput("br_restored", 3, 4, 36, 37, 38);
    for (int k = 0; k < 9; k++) applyStimulus(3, 0, 0, 0, 0, 0, 0);
    checkOutput("br_drain", 2, 31, 63, 7, 0);

    // Recovering an entirely consumed list must yield full, not empty.
    doReset();
    for (int k = 0; k < 10; k++) applyStimulus(3, 0, 0, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 0, 0);
    checkOutput("full_empty", 0, 32, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("full_restored", 3, 0, 32, 33, 34);
    for (int k = 0; k < 10; k++) applyStimulus(3, 0, 0, 0, 0, 0, 0);
    checkOutput("full_drain", 2, 30, 62, 63, 0);

    doReset();
    log_q.delete();
    for (int i = 32; i < 64; i++) log_q.push_back(i);
    head_abs   = 0;
    ckpt_valid = 0;
    ckpt_abs   = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int rd, wr, br, limit, base, cnt, avail;
      int w [3];
      modelCheck(cyc);
      cnt   = log_q.size() - head_abs;
      avail = (cnt < 3) ? cnt : 3;
      rd    = int'($urandom_range(0, 3));
      br    = 0;
      if (ckpt_valid == 0 && $urandom_range(0, 7) == 0) begin
        ckpt_abs   = head_abs;
        ckpt_valid = 1;
      end else if (ckpt_valid != 0 && $urandom_range(0, 5) == 0) begin
        br = 1;
      end
      base  = (ckpt_valid != 0) ? ckpt_abs : head_abs;
      limit = 32 - (log_q.size() - base);
      wr    = int'($urandom_range(0, 3));
      if (wr > limit) wr = limit;
      for (int i = 0; i < 3; i++) w[i] = int'($urandom_range(0, 63));
      applyStimulus(rd, wr, w[0], w[1], w[2], br, ckpt_abs % 64);
      for (int i = 0; i < wr; i++) log_q.push_back(w[i]);
      if (br != 0) begin
        head_abs   = ckpt_abs;
        ckpt_valid = 0;
      end else begin
        head_abs += (rd < avail) ? rd : avail;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- N-way circular free list of physical register indices for the R10K rename stage.
- Dispatch pops up to N free tags per cycle, which become the new T values written into the ROB.
- Retirement pushes back up to N T_old tags per cycle, taken from ROB retiring_data and num_retired.
- On a mispredict, the head pointer is restored from a branch-stack checkpoint, which reclaims every tag allocated since that branch.

Parameters:
DEPTH, `PHYS_REG_SZ_R10K (64), total physical registers
ARCH_REGS, 32, architectural registers; tags 0..ARCH_REGS-1 are mapped at reset
N, `N (3), superscalar width
(derived) SZ = DEPTH-ARCH_REGS, list capacity; must be a power of two; PTR_W = $clog2(SZ)+1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
rd_num  in  $clog2(N+1)  number of tags dispatch consumes this cycle
wr_reg  in  N x PHYS_REG_IDX  freed tags (T_old), [0] oldest
wr_num  in  $clog2(N+1)  number of valid wr_reg entries (ROB num_retired)
br_en  in  1  mispredict recovery this cycle
br_head  in  PTR_W  checkpointed head pointer from the branch stack
free_regs  out  N x PHYS_REG_IDX  next tags to allocate; [i] is valid iff i < num_avail
num_avail  out  $clog2(N+1)  min(N, count)
out_head  out  PTR_W  current head pointer, used for branch checkpointing

Behaviour:
- Storage and pointers:
  - SZ entries of PHYS_REG_IDX.
  - head and tail are PTR_W-bit pointers with a wrap bit; array index = ptr[PTR_W-2:0].
  - count = tail - head, PTR_W-bit unsigned; full when count == SZ.
- Reset (synchronous):
  - entries[i] = ARCH_REGS+i; head = 0; tail = SZ (wrap bit set, index 0); count = SZ.
  - Outputs after reset: free_regs[i] = ARCH_REGS+i, num_avail = N, out_head = 0.
  - Reset takes priority over all other inputs.
- Allocate:
  - free_regs[i] = entries[(head+i) mod SZ], combinational from registered state.
  - Effective pop = min(rd_num, num_avail); excess rd_num is clamped, and the clamp must never cause underflow.
  - Next cycle, head += pop.
- Free:
  - For i < wr_num, entries[(tail+i) mod SZ] <= wr_reg[i]; tail += wr_num.
  - No bypass: freed tags are not visible in free_regs or num_avail until the next cycle.
  - Free never overflows by construction (count + wr_num <= SZ); guard with an assertion only.
- Branch recovery (br_en = 1):
  - next head = br_head; rd_num is ignored because dispatch is stalled during recovery.
  - Frees in the same cycle still apply (retiring instructions are older than the branch).
  - next count = tail + wr_num - br_head, where the wrap bit disambiguates full from empty.
  - The branch is always first in its dispatch group, so the checkpoint is out_head taken in the branch's dispatch cycle.
- Wrap-around: pointer increments are modulo 2*SZ; index reads and writes are modulo SZ; the wrap bit toggles each pass.
- Empty (count = 0): num_avail = 0, free_regs contents are don't-care, pops are clamped to 0.
- Full (count = SZ): num_avail = N; a free into a full list is an assertion failure.
- Simultaneous alloc + free: both apply in the same cycle; next count = count - pop + wr_num.
- The block has no internal FSM; state is head, tail and entries. All outputs are derived from registered state only; there is no combinational path from wr_* to any output.

Decomposition:
- Shared package (sys_defs.svh):
  - FL_SZ constant = `PHYS_REG_SZ_R10K - 32.
  - FL_PTR typedef, logic [$clog2(FL_SZ):0], reused by the branch-stack checkpoint record.
  - PHYS_REG_IDX, already present.
- No sub-module required; the single always_comb plus always_ff is sufficient.
- The DEBUG outputs debug_entries, debug_head and debug_tail follow the existing ifdef pattern.

Test Plan:
- Reset, then idle -> free_regs = {32,33,34}, num_avail = 3, out_head = 0; state unchanged over 5 cycles.
- rd_num = 3 for 10 cycles, then rd_num = 2 -> list empties at head = 32, num_avail = 0; further rd_num = 3 leaves head unchanged (clamp).
- From empty, free tags 5,9,12 (wr_num = 3) with rd_num = 3 in the same cycle -> that cycle num_avail = 0 (no bypass); next cycle free_regs = {5,9,12}, num_avail = 3.
- Wrap: allocate 30, free 30 in 10 batches of 3, then allocate 6 -> index wraps past 31 to 0..3 with the head wrap bit toggled; tags are returned in FIFO order.
- Checkpoint out_head = 4, allocate 9 more (head = 13), then br_en with br_head = 4 and wr_num = 1 (tag 7) -> next head = 4, count = previous count + 9 + 1, free_regs = original tags at 4..6.
- Allocate all 32 tags since the checkpoint (head = br_head + 32, count = 0), then br_en -> count = 32 (full), not 0.
